// File: rtl/test_status_unit_if.sv
// Data-bus slice seen by the test-status peripheral: store request in,
// combinational read data and window-hit indication out.
interface test_status_unit_if;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        hit;

  // CPU / bench side drives the request and observes the response.
  modport master (
    output d_addr, d_wdata, d_we, d_mask,
    input  d_rdata, hit
  );

  // Peripheral side.
  modport slave (
    input  d_addr, d_wdata, d_we, d_mask,
    output d_rdata, hit
  );
endinterface

// File: rtl/test_status_unit.sv
// Test-completion peripheral. Firmware stores a verdict word to STATUS; the
// first full-word store latches PASS or FAIL, and a cycle watchdog flags a
// hung program. Register window: STATUS, CODE, CYCLES, SCRATCH.
module test_status_unit #(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FFF0,
  parameter logic [31:0] PASS_CODE      = 32'h0000_0001,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  test_status_unit_if.slave   bus,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [31:0]         fail_code
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_PASSED    = 2'd1,
    ST_FAILED    = 2'd2,
    ST_TIMED_OUT = 2'd3
  } state_t;

  // A zero limit turns the watchdog off; the counter then simply wraps.
  localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES) - 32'd1;

  localparam logic [3:0] OFF_STATUS  = 4'h0;
  localparam logic [3:0] OFF_CODE    = 4'h4;
  localparam logic [3:0] OFF_CYCLES  = 4'h8;
  localparam logic [3:0] OFF_SCRATCH = 4'hC;

  state_t      state_q,     state_d;
  logic [31:0] code_q,      code_d;
  logic [31:0] fail_code_q, fail_code_d;
  logic [31:0] cycles_q,    cycles_d;
  logic [31:0] scratch_q,   scratch_d;

  logic [31:0] offset_full;
  logic [3:0]  offset;
  logic        hit_w;
  logic        status_wr;
  logic        scratch_wr;

  // Address decode. Subtracting the base avoids overflow when the window
  // sits at the very top of the address space.
  always_comb begin
    offset_full = bus.d_addr - BASE_ADDR;
    hit_w       = (bus.d_addr >= BASE_ADDR) && (offset_full < 32'd16);
    offset      = offset_full[3:0];
    // Only a full-word store to STATUS may carry a verdict; partial stores
    // could leave a torn value, so they are dropped.
    status_wr   = bus.d_we && hit_w && (offset == OFF_STATUS) && (bus.d_mask == 4'hF);
    scratch_wr  = bus.d_we && hit_w && (offset == OFF_SCRATCH);
  end

  // Verdict FSM and watchdog: first qualifying event wins, terminal states hold.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    fail_code_d = fail_code_q;
    cycles_d    = cycles_q;
    if (state_q == ST_RUN) begin
      // On expiry this lands exactly on TIMEOUT_CYCLES, then freezes.
      cycles_d = cycles_q + 32'd1;
      if (status_wr) begin
        // A firmware verdict on the expiry edge takes priority.
        code_d = bus.d_wdata;
        if (bus.d_wdata == PASS_CODE) begin
          state_d = ST_PASSED;
        end else begin
          state_d     = ST_FAILED;
          fail_code_d = bus.d_wdata;
        end
      end else if (WDOG_EN && (cycles_q == LAST_CYCLE)) begin
        state_d = ST_TIMED_OUT;
      end
    end
  end

  // SCRATCH stays writable in every state, byte by byte.
  always_comb begin
    scratch_d = scratch_q;
    if (scratch_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.d_mask[b]) begin
          scratch_d[8*b +: 8] = bus.d_wdata[8*b +: 8];
        end
      end
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      code_q      <= 32'd0;
      fail_code_q <= 32'd0;
      cycles_q    <= 32'd0;
      scratch_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      fail_code_q <= fail_code_d;
      cycles_q    <= cycles_d;
      scratch_q   <= scratch_d;
    end
  end

  // Read mux, combinational from the address; unaligned or outside reads give 0.
  always_comb begin
    bus.d_rdata = 32'd0;
    if (hit_w) begin
      case (offset)
        OFF_STATUS:  bus.d_rdata = {28'd0, timeout, fail, pass, done};
        OFF_CODE:    bus.d_rdata = code_q;
        OFF_CYCLES:  bus.d_rdata = cycles_q;
        OFF_SCRATCH: bus.d_rdata = scratch_q;
        default:     bus.d_rdata = 32'd0;
      endcase
    end
  end

  assign bus.hit   = hit_w;
  assign done      = (state_q != ST_RUN);
  assign pass      = (state_q == ST_PASSED);
  assign fail      = (state_q == ST_FAILED);
  assign timeout   = (state_q == ST_TIMED_OUT);
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_test_status_unit.sv
// Bench for test_status_unit: vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model. Two instances share
// one bus: A with a 10-cycle watchdog, B with the watchdog disabled.
module tb_test_status_unit;

  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
  localparam logic [31:0] PASSC = 32'h0000_0001;
  localparam int unsigned TO_A  = 10;
  localparam int unsigned TO_B  = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  test_status_unit_if bus_a ();
  test_status_unit_if bus_b ();

  assign bus_b.d_addr  = bus_a.d_addr;
  assign bus_b.d_wdata = bus_a.d_wdata;
  assign bus_b.d_we    = bus_a.d_we;
  assign bus_b.d_mask  = bus_a.d_mask;

  logic        done_a, pass_a, fail_a, timeout_a;
  logic        done_b, pass_b, fail_b, timeout_b;
  logic [31:0] fcode_a, fcode_b;
  logic [3:0]  flags_a, flags_b;
  assign flags_a = {timeout_a, fail_a, pass_a, done_a};
  assign flags_b = {timeout_b, fail_b, pass_b, done_b};

  test_status_unit #(.BASE_ADDR(BASE), .PASS_CODE(PASSC), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a), .fail_code(fcode_a)
  );

  test_status_unit #(.BASE_ADDR(BASE), .PASS_CODE(PASSC), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b), .fail_code(fcode_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic setbus(input logic [31:0] a, input logic [31:0] w, input logic we, input logic [3:0] mk);
    bus_a.d_addr  = a;
    bus_a.d_wdata = w;
    bus_a.d_we    = we;
    bus_a.d_mask  = mk;
  endtask

  // Every task starts and ends 1 time unit after a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    setbus(32'd0, 32'd0, 1'b0, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- behavioural model ----------------
  // st: 0 running, 1 passed, 2 failed, 3 timed out
  typedef struct {
    int          st;
    logic [31:0] code;
    logic [31:0] fcode;
    logic [31:0] cyc;
    logic [31:0] scr;
  } mdl_t;

  function automatic mdl_t m_init();
    mdl_t m;
    m.st = 0; m.code = 0; m.fcode = 0; m.cyc = 0; m.scr = 0;
    return m;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    longint unsigned lo, x;
    lo = longint'(BASE);
    x  = longint'(a);
    return (x >= lo) && (x <= lo + 15);
  endfunction

  function automatic logic [3:0] m_flags(input mdl_t m);
    return {m.st == 3, m.st == 2, m.st == 1, m.st != 0};
  endfunction

  function automatic logic [31:0] m_read(input mdl_t m, input logic [31:0] a);
    logic [31:0] off;
    if (!m_hit(a)) return 32'd0;
    off = a - BASE;
    case (off)
      32'd0:   return {28'd0, m_flags(m)};
      32'd4:   return m.code;
      32'd8:   return m.cyc;
      32'd12:  return m.scr;
      default: return 32'd0;
    endcase
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input int unsigned to, input logic [31:0] a,
                                  input logic [31:0] w, input logic we, input logic [3:0] mk);
    mdl_t n;
    logic [31:0] off;
    n   = m;
    off = a - BASE;
    if (m.st == 0) begin
      n.cyc = m.cyc + 1;
      if (we && m_hit(a) && off == 0 && mk == 4'hF) begin
        n.code = w;
        if (w == PASSC) n.st = 1;
        else begin n.st = 2; n.fcode = w; end
      end else if (to != 0 && longint'(m.cyc) + 1 == longint'(to)) begin
        n.st = 3;
      end
    end
    if (we && m_hit(a) && off == 12)
      for (int b = 0; b < 4; b++)
        if (mk[b]) n.scr[8*b +: 8] = w[8*b +: 8];
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  mask;
    logic [3:0]  flags;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Watchdog safety net: the bench normally ends long before this.
    #2_000_000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    mdl_t ma, mb;
    logic [31:0] a, w;
    logic we;
    logic [3:0] mk;

    // addr, wdata, we, mask -> flags {to,fail,pass,done}, hit, rdata (same addr, after edge)
    tbl[0] = '{BASE,        32'h0000_0001, 1'b1, 4'hF, 4'b0011, 1'b1, 32'h0000_0003};
    tbl[1] = '{BASE,        32'h0000_0007, 1'b1, 4'hF, 4'b0011, 1'b1, 32'h0000_0003};
    tbl[2] = '{BASE + 4,    32'h0,         1'b0, 4'h0, 4'b0011, 1'b1, 32'h0000_0001};
    tbl[3] = '{BASE + 12,   32'hDEAD_BEEF, 1'b1, 4'hF, 4'b0011, 1'b1, 32'hDEAD_BEEF};
    tbl[4] = '{BASE + 12,   32'h0000_1234, 1'b1, 4'h3, 4'b0011, 1'b1, 32'hDEAD_1234};
    // BASE+16 wraps to address 0: outside the window.
    tbl[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, 4'b0011, 1'b0, 32'h0};
    tbl[6] = '{BASE + 12,   32'h0,         1'b0, 4'h0, 4'b0011, 1'b1, 32'hDEAD_1234};
    // Cycle counter froze at 1: the verdict edge was the first edge after reset.
    tbl[7] = '{BASE + 8,    32'h0,         1'b0, 4'h0, 4'b0011, 1'b1, 32'h0000_0001};
    tbl[8] = '{BASE + 1,    32'h0000_0005, 1'b1, 4'hF, 4'b0011, 1'b1, 32'h0};

    reset = 1'b0;
    setbus(32'd0, 32'd0, 1'b0, 4'h0);
    @(negedge clk);
    #1;

    // Reset state
    do_reset();
    chk("reset_flags", {28'd0, flags_a}, 32'd0);
    chk("reset_fail_code", fcode_a, 32'd0);
    setbus(BASE, 32'd0, 1'b0, 4'h0);
    #1;
    chk("reset_status_read", bus_a.d_rdata, 32'd0);
    chk("reset_hit", {31'd0, bus_a.hit}, 32'd1);

    // Table: pass verdict, sticky verdict, scratch, window edges
    for (int i = 0; i < 9; i++) begin
      setbus(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].mask);
      step();
      chk($sformatf("tbl%0d_flags", i), {28'd0, flags_a}, {28'd0, tbl[i].flags});
      chk($sformatf("tbl%0d_hit", i), {31'd0, bus_a.hit}, {31'd0, tbl[i].hit});
      chk($sformatf("tbl%0d_rdata", i), bus_a.d_rdata, tbl[i].rdata);
    end

    // Fail verdict sticks against a later pass
    do_reset();
    setbus(BASE, 32'h0000_0007, 1'b1, 4'hF);
    step();
    chk("fail_flags", {28'd0, flags_a}, 32'h5);
    chk("fail_code", fcode_a, 32'h7);
    setbus(BASE, PASSC, 1'b1, 4'hF);
    step();
    chk("fail_sticky_flags", {28'd0, flags_a}, 32'h5);
    setbus(BASE + 4, 32'd0, 1'b0, 4'h0);
    #1;
    chk("fail_code_reg", bus_a.d_rdata, 32'h7);

    // Watchdog expiry exactly on edge 10, then frozen; B never expires
    do_reset();
    setbus(BASE + 8, 32'd0, 1'b0, 4'h0);
    idle(9);
    chk("wd_pre_flags", {28'd0, flags_a}, 32'h0);
    chk("wd_pre_cycles", bus_a.d_rdata, 32'd9);
    step();
    chk("wd_flags", {28'd0, flags_a}, 32'h9);
    chk("wd_cycles", bus_a.d_rdata, 32'd10);
    idle(5);
    chk("wd_frozen_cycles", bus_a.d_rdata, 32'd10);
    chk("wd_frozen_flags", {28'd0, flags_a}, 32'h9);
    chk("wd_off_flags", {28'd0, flags_b}, 32'h0);
    chk("wd_off_cycles", bus_b.d_rdata, 32'd15);

    // Verdict on the expiry edge wins
    do_reset();
    idle(9);
    setbus(BASE, PASSC, 1'b1, 4'hF);
    step();
    chk("race_flags", {28'd0, flags_a}, 32'h3);

    // Partial-mask STATUS stores change nothing
    do_reset();
    setbus(BASE, PASSC, 1'b1, 4'h3);
    step();
    chk("pmask_pass_flags", {28'd0, flags_a}, 32'h0);
    setbus(BASE, 32'h0000_0007, 1'b1, 4'hE);
    step();
    chk("pmask_fail_flags", {28'd0, flags_a}, 32'h0);
    chk("pmask_fail_code", fcode_a, 32'h0);
    setbus(BASE + 4, 32'd0, 1'b0, 4'h0);
    #1;
    chk("pmask_code", bus_a.d_rdata, 32'h0);

    // Asynchronous reset after a fail clears state without a clock edge
    do_reset();
    setbus(BASE, 32'h0000_0042, 1'b1, 4'hF);
    step();
    chk("areset_pre_flags", {28'd0, flags_a}, 32'h5);
    setbus(BASE + 8, 32'd0, 1'b0, 4'h0);
    reset = 1'b0;
    #1;
    chk("areset_flags", {28'd0, flags_a}, 32'h0);
    chk("areset_fail_code", fcode_a, 32'h0);
    chk("areset_cycles", bus_a.d_rdata, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    chk("areset_restart_cycles", bus_a.d_rdata, 32'd3);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      do_reset();
      ma = m_init();
      mb = m_init();
      for (int c = 0; c < 24; c++) begin
        case ($urandom_range(0, 7))
          0, 7:    a = BASE;
          1:       a = BASE + 4;
          2:       a = BASE + 8;
          3:       a = BASE + 12;
          4:       a = BASE + $urandom_range(1, 15);
          5:       a = BASE - 4;
          default: a = $urandom;
        endcase
        w  = $urandom_range(0, 1) ? PASSC : $urandom;
        we = ($urandom_range(0, 3) == 0);
        mk = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
        setbus(a, w, we, mk);
        #1;
        chk("rnd_hit", {31'd0, bus_a.hit}, {31'd0, m_hit(a)});
        chk("rnd_rdata_a", bus_a.d_rdata, m_read(ma, a));
        chk("rnd_rdata_b", bus_b.d_rdata, m_read(mb, a));
        step();
        ma = m_step(ma, TO_A, a, w, we, mk);
        mb = m_step(mb, TO_B, a, w, we, mk);
        chk("rnd_flags_a", {28'd0, flags_a}, {28'd0, m_flags(ma)});
        chk("rnd_flags_b", {28'd0, flags_b}, {28'd0, m_flags(mb)});
        chk("rnd_fcode_a", fcode_a, ma.fcode);
        chk("rnd_fcode_b", fcode_b, mb.fcode);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
